dram_dma_arbiter: RTL

// - Shares the single bsg_cache DMA port of mig_ddr3_ram between num_req_p DMA masters (core L2, debug/NBF loader).
// - Round-robin arbitration on DMA packets; steers write-data beats from the packet owner and in-order read-data beats back to the issuer.
// - Sits between the requesters and the DRAM controller, entirely in the core clock domain.

---
 rtl/dram_dma_arbiter_pkg.sv | 27 ++
 rtl/dram_dma_rd_tag_fifo.sv | 65 ++++++
 rtl/dram_dma_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dram_dma_arbiter_pkg.sv
// Shared types and width helpers for the DRAM DMA arbiter.
//
// DMA packet layout (flat vector, dma_pkt_width(caddr) bits):
//   [caddr]     write_not_read
//   [caddr-1:0] cache block address
package dram_dma_arbiter_pkg;

    typedef enum logic [0:0] {
        e_idle    = 1'b0,
        e_wr_data = 1'b1
    } arb_state_e;

    function automatic int dma_pkt_width(input int caddr_width);
        return caddr_width + 1;
    endfunction

    // Width of a requester id; never narrower than one bit.
    function automatic int owner_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of a beat counter; a single-beat block still gets one bit.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/dram_dma_rd_tag_fifo.sv
// In-order FIFO of read-packet owner ids. A read packet pushes its
// requester id when issued; the read-return path pops it after the last
// beat of that block has been delivered.
//
// Ports:
//   clk_i, reset_i  core clock, synchronous active-high reset
//   push_i, data_i  push an owner id (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   head_o          owner id at the head
//   empty_o/full_o  occupancy flags
module dram_dma_rd_tag_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] head_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wptr_q, rptr_q;
    logic [cnt_w-1:0]   count_q;
    logic               push_ok, pop_ok;

    // Explicit wrap so depths that are not a power of two still work.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == cnt_w'(els_p));
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= next_ptr(wptr_q);
            if (pop_ok)  rptr_q <= next_ptr(rptr_q);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/dram_dma_arbiter.sv
// Shares one DMA port of the DRAM controller between num_req_p DMA masters.
// Packets are granted round-robin; a write packet locks the arbiter onto
// its owner until the block's write beats have been forwarded, while read
// data returns in issue order to whichever requester issued each read.
//
// Ports:
//   clk_i, reset_i              core clock, synchronous active-high reset
//   req_dma_pkt_i/_v_i/_yumi_o  per-requester packet channel
//   req_dma_data_o/_v_o/_ready_and_i  read beats to requesters (shared bus,
//                               one-hot valid to the read owner)
//   req_dma_data_i/_v_i/_yumi_o per-requester write beats
//   mem_dma_pkt_o/_v_o/_yumi_i  packet to the DRAM controller
//   mem_dma_data_i/_v_i/_ready_and_o  read beats from DRAM
//   mem_dma_data_o/_v_o/_yumi_i write beats to DRAM
module dram_dma_arbiter
    import dram_dma_arbiter_pkg::*;
#(
    parameter int num_req_p     = 2,
    parameter int caddr_width_p = 28,
    parameter int fill_width_p  = 64,
    parameter int block_width_p = 512,
    parameter int rd_tag_els_p  = 4
) (
    input  logic                                               clk_i,
    input  logic                                               reset_i,

    input  logic [num_req_p*dma_pkt_width(caddr_width_p)-1:0] req_dma_pkt_i,
    input  logic [num_req_p-1:0]                               req_dma_pkt_v_i,
    output logic [num_req_p-1:0]                               req_dma_pkt_yumi_o,

    output logic [fill_width_p-1:0]                            req_dma_data_o,
    output logic [num_req_p-1:0]                               req_dma_data_v_o,
    input  logic [num_req_p-1:0]                               req_dma_data_ready_and_i,

    input  logic [num_req_p*fill_width_p-1:0]                  req_dma_data_i,
    input  logic [num_req_p-1:0]                               req_dma_data_v_i,
    output logic [num_req_p-1:0]                               req_dma_data_yumi_o,

    output logic [dma_pkt_width(caddr_width_p)-1:0]            mem_dma_pkt_o,
    output logic                                               mem_dma_pkt_v_o,
    input  logic                                               mem_dma_pkt_yumi_i,

    input  logic [fill_width_p-1:0]                            mem_dma_data_i,
    input  logic                                               mem_dma_data_v_i,
    output logic                                               mem_dma_data_ready_and_o,

    output logic [fill_width_p-1:0]                            mem_dma_data_o,
    output logic                                               mem_dma_data_v_o,
    input  logic                                               mem_dma_data_yumi_i
);

    localparam int pkt_w    = dma_pkt_width(caddr_width_p);
    localparam int beats_lp = block_width_p / fill_width_p;
    localparam int id_w     = owner_id_width(num_req_p);
    localparam int cnt_w    = beat_cnt_width(beats_lp);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats_lp - 1);

    arb_state_e        state_q, state_d;
    logic [id_w-1:0]   rr_q, rr_d;
    logic [id_w-1:0]   wr_owner_q, wr_owner_d;
    logic [cnt_w-1:0]  wr_cnt_q, wr_cnt_d;
    logic [cnt_w-1:0]  rd_cnt_q, rd_cnt_d;

    logic [pkt_w-1:0]        pkt_a   [num_req_p];
    logic [fill_width_p-1:0] wdata_a [num_req_p];
    logic [num_req_p-1:0]    pkt_wnr;
    logic [num_req_p-1:0]    eligible;

    logic              tag_full, tag_empty, tag_push, tag_pop;
    logic [id_w-1:0]   tag_head;

    logic              grant_v;
    logic [id_w-1:0]   grant_id;
    logic [id_w:0]     idx_w;
    logic              pkt_accept;
    logic              wr_active, wr_beat;
    logic              rd_live, rd_beat, rd_last;

    // Unpack the flat requester buses and decide who may bid this cycle.
    // Writes are never held back by the tag FIFO; reads need a free slot.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
        assign pkt_a[gi]    = req_dma_pkt_i[gi*pkt_w +: pkt_w];
        assign wdata_a[gi]  = req_dma_data_i[gi*fill_width_p +: fill_width_p];
        assign pkt_wnr[gi]  = pkt_a[gi][pkt_w-1];
        assign eligible[gi] = req_dma_pkt_v_i[gi] & (pkt_wnr[gi] | ~tag_full)
                            & (state_q == e_idle) & ~reset_i;
    end

    // Round-robin pick: scan from the farthest candidate back to rr_q so
    // the nearest eligible requester is the one left standing.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        idx_w    = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx_w = {1'b0, rr_q} + (id_w + 1)'(k);
            if (idx_w >= (id_w + 1)'(num_req_p)) idx_w = idx_w - (id_w + 1)'(num_req_p);
            if (eligible[idx_w[id_w-1:0]]) begin
                grant_v  = 1'b1;
                grant_id = idx_w[id_w-1:0];
            end
        end
    end

    // Packet path
    assign mem_dma_pkt_o      = pkt_a[grant_id];
    assign mem_dma_pkt_v_o    = grant_v;
    assign pkt_accept         = grant_v & mem_dma_pkt_yumi_i;
    assign req_dma_pkt_yumi_o = pkt_accept ? (num_req_p'(1) << grant_id) : '0;

    // Write-data path: only the packet owner is connected, only in e_wr_data.
    assign wr_active           = (state_q == e_wr_data) & ~reset_i;
    assign mem_dma_data_o      = wdata_a[wr_owner_q];
    assign mem_dma_data_v_o    = wr_active & req_dma_data_v_i[wr_owner_q];
    assign wr_beat             = wr_active & mem_dma_data_yumi_i;
    assign req_dma_data_yumi_o = wr_beat ? (num_req_p'(1) << wr_owner_q) : '0;

    // Read-return path: runs regardless of state, steered by the tag head.
    assign rd_live                  = ~tag_empty & ~reset_i;
    assign mem_dma_data_ready_and_o = rd_live & req_dma_data_ready_and_i[tag_head];
    assign req_dma_data_v_o         = (mem_dma_data_v_i & rd_live) ? (num_req_p'(1) << tag_head) : '0;
    assign req_dma_data_o           = mem_dma_data_i;
    assign rd_beat                  = mem_dma_data_v_i & mem_dma_data_ready_and_o;
    assign rd_last                  = rd_beat & (rd_cnt_q == last_beat);

    assign tag_push = pkt_accept & ~pkt_wnr[grant_id];
    assign tag_pop  = rd_last;

    dram_dma_rd_tag_fifo #(
        .els_p   (rd_tag_els_p),
        .width_p (id_w)
    ) u_rd_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (tag_push),
        .data_i  (grant_id),
        .pop_i   (tag_pop),
        .head_o  (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    // Next-state logic. A packet can only be accepted in e_idle and a write
    // beat only in e_wr_data, so the two updates below never collide.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        wr_owner_d = wr_owner_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;

        if (pkt_accept) begin
            rr_d = (grant_id == id_w'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
            if (pkt_wnr[grant_id]) begin
                state_d    = e_wr_data;
                wr_owner_d = grant_id;
                wr_cnt_d   = '0;
            end
        end

        if (wr_beat) begin
            // Explicit clear keeps single-beat blocks correct.
            wr_cnt_d = (wr_cnt_q == last_beat) ? '0 : wr_cnt_q + 1'b1;
            if (wr_cnt_q == last_beat) state_d = e_idle;
        end

        if (rd_beat) begin
            rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            rr_q       <= '0;
            wr_owner_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            wr_owner_q <= wr_owner_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // DRAM must never return read data that no requester is waiting for.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_dma_data_v_i && tag_empty));
        end
    end

endmodule
